// File: rtl/costas_err_detect.sv
// Costas-loop phase-error detector with BPSK/QPSK folding.
// Two-stage pipeline; samples carry their mode tag, hold window zeroes error.
module costas_err_detect #(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    is_bpsk,
  input  logic signed [WIDTH-1:0] in_I_tdata,
  input  logic signed [WIDTH-1:0] in_Q_tdata,
  input  logic                    in_tvalid,
  output logic signed [WIDTH-1:0] out_I_tdata,
  output logic signed [WIDTH-1:0] out_Q_tdata,
  output logic                    out_tvalid,
  output logic signed [WIDTH-1:0] error_tdata,
  output logic                    error_tvalid,
  output logic                    mode_active,
  output logic                    holding
);

  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0] SAT_MAX =
    {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN =
    {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit HOLD_EN = (HOLD_CYCLES > 0);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic signed [WIDTH-1:0] sat(
    input logic signed [XW-1:0] x
  );
    logic signed [WIDTH-1:0] r;
    if (x > SAT_MAX) begin
      r = SAT_MAX[WIDTH-1:0];
    end else if (x < SAT_MIN) begin
      r = SAT_MIN[WIDTH-1:0];
    end else begin
      r = x[WIDTH-1:0];
    end
    return r;
  endfunction

  // stage 1 and mode state
  logic signed [WIDTH-1:0] s1_i_q, s1_i_d;
  logic signed [WIDTH-1:0] s1_q_q, s1_q_d;
  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_tag_q, s1_tag_d;
  logic                    active_q, active_d;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // stage 2 (registered outputs)
  logic signed [WIDTH-1:0] out_i_q, out_i_d;
  logic signed [WIDTH-1:0] out_q_q, out_q_d;
  logic signed [WIDTH-1:0] err_q, err_d;
  logic                    out_vld_q, out_vld_d;
  logic                    mode_q, mode_d;
  logic                    hold_q, hold_d;

  logic signed [XW-1:0]    i_x, q_x, a_x, b_x, d_x;
  logic signed [WIDTH-1:0] f_i, f_q, f_err;
  logic                    switch_req, new_tag_out, zero_err;

  // fold and phase error from the stage-1 sample, using its own tag
  always_comb begin
    i_x   = {{2{s1_i_q[WIDTH-1]}}, s1_i_q};
    q_x   = {{2{s1_q_q[WIDTH-1]}}, s1_q_q};
    a_x   = s1_i_q[WIDTH-1] ? -q_x : q_x;
    b_x   = s1_q_q[WIDTH-1] ? -i_x : i_x;
    d_x   = a_x - b_x;
    f_i   = s1_i_q;
    f_q   = s1_q_q;
    f_err = sat(a_x);
    if (!s1_tag_q) begin
      f_i   = sat(b_x);
      f_q   = sat(a_x);
      f_err = sat(d_x);
    end
  end

  // mode tracking and hold window bookkeeping
  always_comb begin
    switch_req  = (is_bpsk != active_q);
    new_tag_out = s1_vld_q && (s1_tag_q == active_q);
    zero_err    = (state_q == HOLD) && new_tag_out;
    active_d    = is_bpsk;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (switch_req) begin
      if (HOLD_EN) begin
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
      end
    end else if (zero_err) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = RUN;
      end
    end
  end

  // next values for both pipeline stages
  always_comb begin
    s1_vld_d  = in_tvalid;
    s1_i_d    = s1_i_q;
    s1_q_d    = s1_q_q;
    s1_tag_d  = s1_tag_q;
    if (in_tvalid) begin
      s1_i_d   = in_I_tdata;
      s1_q_d   = in_Q_tdata;
      s1_tag_d = active_q;
    end
    out_vld_d = s1_vld_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;
    err_d     = err_q;
    mode_d    = mode_q;
    if (s1_vld_q) begin
      out_i_d = f_i;
      out_q_d = f_q;
      err_d   = zero_err ? '0 : f_err;
      mode_d  = s1_tag_q;
    end
    hold_d = (state_q == HOLD);
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_i_q    <= '0;
      s1_q_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_tag_q  <= 1'b1;
      active_q  <= 1'b1;
      state_q   <= RUN;
      cnt_q     <= '0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      err_q     <= '0;
      out_vld_q <= 1'b0;
      mode_q    <= 1'b1;
      hold_q    <= 1'b0;
    end else begin
      s1_i_q    <= s1_i_d;
      s1_q_q    <= s1_q_d;
      s1_vld_q  <= s1_vld_d;
      s1_tag_q  <= s1_tag_d;
      active_q  <= active_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
      mode_q    <= mode_d;
      hold_q    <= hold_d;
    end
  end

  assign out_I_tdata  = out_i_q;
  assign out_Q_tdata  = out_q_q;
  assign out_tvalid   = out_vld_q;
  assign error_tdata  = err_q;
  assign error_tvalid = out_vld_q;
  assign mode_active  = mode_q;
  assign holding      = hold_q;

endmodule

// File: tb/tb_costas_err_detect.sv
// Bench for costas_err_detect: vector table, hand sequences,
// and random traffic against a cycle-level reference model.
module tb_costas_err_detect;

  localparam int W    = 16;
  localparam int HOLD = 8;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                clk = 1'b0;
  logic                rst;
  logic                is_bpsk;
  logic signed [W-1:0] in_I_tdata;
  logic signed [W-1:0] in_Q_tdata;
  logic                in_tvalid;
  logic signed [W-1:0] out_I_tdata;
  logic signed [W-1:0] out_Q_tdata;
  logic                out_tvalid;
  logic signed [W-1:0] error_tdata;
  logic                error_tvalid;
  logic                mode_active;
  logic                holding;

  costas_err_detect #(
    .WIDTH(W), .HOLD_CYCLES(HOLD), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .is_bpsk(is_bpsk),
    .in_I_tdata(in_I_tdata), .in_Q_tdata(in_Q_tdata),
    .in_tvalid(in_tvalid),
    .out_I_tdata(out_I_tdata), .out_Q_tdata(out_Q_tdata),
    .out_tvalid(out_tvalid),
    .error_tdata(error_tdata), .error_tvalid(error_tvalid),
    .mode_active(mode_active), .holding(holding)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      if (errs < 40)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic int sgn(input int x);
    return (x >= 0) ? 1 : -1;
  endfunction

  // reference model: sample in stage 1, newest mode, remaining holds
  typedef struct {
    bit v;
    int i;
    int q;
    bit tag;
  } smp_t;

  smp_t m_s1;
  bit   m_active;
  int   m_rem;
  bit   e_vld, e_mode, e_hold;
  int   e_oi, e_oq, e_err;

  task automatic model_edge(input bit r, input bit b, input bit v,
                            input int i, input int q);
    bit zero;
    bit old_active;
    if (r) begin
      m_s1 = '{v: 1'b0, i: 0, q: 0, tag: 1'b1};
      m_active = 1'b1;
      m_rem = 0;
      e_vld = 0; e_mode = 1; e_hold = 0;
      e_oi = 0; e_oq = 0; e_err = 0;
      return;
    end
    e_hold = (m_rem > 0);
    zero = (m_rem > 0) && m_s1.v && (m_s1.tag == m_active);
    e_vld = m_s1.v;
    if (m_s1.v) begin
      if (m_s1.tag) begin
        e_oi  = m_s1.i;
        e_oq  = m_s1.q;
        e_err = clamp(sgn(m_s1.i) * m_s1.q);
      end else begin
        e_oi  = clamp(sgn(m_s1.q) * m_s1.i);
        e_oq  = clamp(sgn(m_s1.i) * m_s1.q);
        e_err = clamp(sgn(m_s1.i) * m_s1.q - sgn(m_s1.q) * m_s1.i);
      end
      if (zero) e_err = 0;
      e_mode = m_s1.tag;
    end
    old_active = m_active;
    if (b != m_active) begin
      m_active = b;
      m_rem = HOLD;
    end else if (zero) begin
      m_rem--;
    end
    if (v) m_s1 = '{v: 1'b1, i: i, q: q, tag: old_active};
    else m_s1.v = 1'b0;
  endtask

  task automatic step(input bit r, input bit b, input bit v,
                      input int i, input int q);
    rst = r;
    is_bpsk = b;
    in_tvalid = v;
    in_I_tdata = W'(i);
    in_Q_tdata = W'(q);
    model_edge(r, b, v, i, q);
    @(posedge clk);
    #1;
    chk("m_vld", int'(out_tvalid), int'(e_vld));
    chk("m_evld", int'(error_tvalid), int'(e_vld));
    chk("m_oi", int'(out_I_tdata), e_oi);
    chk("m_oq", int'(out_Q_tdata), e_oq);
    chk("m_err", int'(error_tdata), e_err);
    chk("m_mode", int'(mode_active), int'(e_mode));
    chk("m_hold", int'(holding), int'(e_hold));
  endtask

  function automatic int rdata();
    int s;
    s = int'($urandom_range(0, 7));
    case (s)
      0: return MINV;
      1: return MAXV;
      2: return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  typedef struct {
    bit b;
    int i;
    int q;
    int oi;
    int oq;
    int err;
  } vec_t;

  vec_t tv[10];
  int n_old, n_held, n_new;
  bit cur_b;
  bit pat[4];

  initial begin
    tv[0] = '{1, 1000, 200, 1000, 200, 200};
    tv[1] = '{0, 1000, -200, -1000, -200, 800};
    tv[2] = '{0, MINV, MINV, MAXV, MAXV, 0};
    tv[3] = '{1, MINV, MINV, MINV, MINV, MAXV};
    tv[4] = '{0, -500, 300, -500, -300, 200};
    tv[5] = '{1, -7, 0, -7, 0, 0};
    tv[6] = '{0, 0, -1, 0, -1, -1};
    tv[7] = '{0, MAXV, MINV, -32767, MINV, -1};
    tv[8] = '{0, MINV, 0, MINV, 0, MAXV};
    tv[9] = '{1, -1, MINV, -1, MINV, MAXV};

    // reset state
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_vld", int'(out_tvalid), 0);
    chk("rst_err", int'(error_tdata), 0);
    chk("rst_mode", int'(mode_active), 1);
    chk("rst_hold", int'(holding), 0);

    // vector table in settled mode
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < 12; s++) step(0, tv[k].b, 1, 5, 3);
      step(0, tv[k].b, 1, tv[k].i, tv[k].q);
      step(0, tv[k].b, 0, 0, 0);
      chk("tv_vld", int'(out_tvalid), 1);
      chk("tv_oi", int'(out_I_tdata), tv[k].oi);
      chk("tv_oq", int'(out_Q_tdata), tv[k].oq);
      chk("tv_err", int'(error_tdata), tv[k].err);
      chk("tv_mode", int'(mode_active), int'(tv[k].b));
    end

    // BPSK -> QPSK with continuous valid
    for (int s = 0; s < 14; s++) step(0, 1, 1, 1000, -200);
    n_old = 0; n_held = 0;
    for (int k = 0; k < 14; k++) begin
      step(0, 0, 1, 1000, -200);
      if (out_tvalid && mode_active) n_old++;
      if (out_tvalid && !mode_active && holding && error_tdata == 0)
        n_held++;
      if (k == 10) begin
        chk("sw_9th_err", int'(error_tdata), 800);
        chk("sw_9th_hold", int'(holding), 0);
      end
    end
    chk("sw_old_tag", n_old, 2);
    chk("sw_held", n_held, 8);

    // switch again while holding: 3 held, then toggle back
    n_held = 0;
    for (int j = 0; j < 18; j++) begin
      step(0, (j < 5) ? 1'b1 : 1'b0, 1, 1000, 200);
      if (j < 5 && out_tvalid && mode_active && error_tdata == 0)
        n_held++;
      if (j == 4) chk("rl_first3", n_held, 3);
      if (j == 4) n_new = 0;
      if (j >= 6 && out_tvalid && !mode_active && error_tdata == 0)
        n_new++;
      if (j == 15) begin
        chk("rl_after_err", int'(error_tdata), -800);
        chk("rl_after_hold", int'(holding), 0);
      end
    end
    chk("rl_reload", n_new, 8);

    // gaps during hold: only valid outputs consume the window
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    n_held = 0;
    for (int k = 0; k < 32; k++) begin
      step(0, 1, pat[k % 4], 1000, 200);
      if (out_tvalid && mode_active && error_tdata == 0) n_held++;
    end
    chk("gap_held", n_held, 8);

    // reset mid-stream
    for (int k = 0; k < 4; k++) step(0, 1, 1, 321, -45);
    step(1, 1, 1, 321, -45);
    chk("mrst_vld", int'(out_tvalid), 0);
    chk("mrst_oi", int'(out_I_tdata), 0);
    chk("mrst_mode", int'(mode_active), 1);
    step(0, 1, 1, 321, -45);
    chk("mrst_stale", int'(out_tvalid), 0);
    step(0, 1, 1, 321, -45);
    chk("mrst_resume", int'(out_tvalid), 1);

    // randomized traffic against the model
    cur_b = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) cur_b = ~cur_b;
      step(($urandom_range(0, 199) == 0), cur_b,
           ($urandom_range(0, 9) < 7), rdata(), rdata());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
